// File: rtl/test_istream_pkg.sv
// Shared definitions for the FL stream test sources and sinks.
package TestStreamPkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SEND  = 2'd2
   } stream_state_e;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/test_istream_utils.sv
// Cycle counter since reset with a sticky timeout flag for stream test harnesses.
module FLTestUtils #(
   parameter int unsigned p_timeout = 10000
)(
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_cycle,
   output logic        o_timeout
);

   logic [31:0] r_cycle;
   logic        r_timeout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cycle   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (r_cycle >= 32'(p_timeout - 1))
            r_timeout <= 1'b1;
      end
   end

   assign o_cycle   = r_cycle;
   assign o_timeout = r_timeout;

endmodule

// File: rtl/test_istream.sv
// FL val/rdy stream source: messages queued via send() are presented one at a
// time, held until accepted, optionally separated by a fixed idle gap.
module test_istream
   import TestStreamPkg::*;
#(
   parameter type         t_msg             = logic [31:0],
   parameter int unsigned p_send_intv_delay = 0,
   parameter int unsigned p_depth           = 16
)(
   input  logic clk,
   input  logic rst,
   output t_msg msg,
   output logic val,
   input  logic rdy,
   output logic idle
);

   localparam int          MSG_W = $bits(t_msg);
   localparam int          HEX_W = (MSG_W + 3) / 4;
   localparam int unsigned CNT_W = cnt_width(p_send_intv_delay + 1);
   localparam int unsigned PTR_W = cnt_width(p_depth);
   localparam int unsigned OCC_W = cnt_width(p_depth + 1);

   localparam logic [CNT_W-1:0] RELOAD =
      CNT_W'((p_send_intv_delay == 0) ? 0 : p_send_intv_delay - 1);
   localparam logic [OCC_W-1:0] DEPTH = OCC_W'(p_depth);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(p_depth - 1);

   t_msg             r_mem [p_depth];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [OCC_W-1:0] r_count;
   logic [CNT_W-1:0] r_cnt;
   stream_state_e    r_state;

   // Push request handshake, driven only by send() between clock edges.
   logic             w_send_req = 1'b0;
   t_msg             w_send_msg = '0;

   logic             w_pop;
   logic             w_push;
   logic [OCC_W-1:0] w_count_next;
   logic [31:0]      w_cycle;
   logic             w_timeout;

   FLTestUtils t (
      .i_clk     (clk),
      .i_rst     (rst),
      .o_cycle   (w_cycle),
      .o_timeout (w_timeout)
   );

   assign w_pop        = (r_state == SEND) && rdy;
   assign w_push       = w_send_req && ((r_count != DEPTH) || w_pop);
   assign w_count_next = r_count + OCC_W'(w_push) - OCC_W'(w_pop);

   // The FSM looks at the post-edge count so a push is seen on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_push)
            r_tail <= (r_tail == LAST) ? '0 : r_tail + PTR_W'(1);
         if (w_pop)
            r_head <= (r_head == LAST) ? '0 : r_head + PTR_W'(1);
         case (r_state)
            IDLE: begin
               if (w_count_next != '0) begin
                  if (p_send_intv_delay == 0) begin
                     r_state <= SEND;
                  end else begin
                     r_state <= DELAY;
                     r_cnt   <= RELOAD;
                  end
               end
            end
            DELAY: begin
               if (r_cnt == '0)
                  r_state <= SEND;
               else
                  r_cnt <= r_cnt - CNT_W'(1);
            end
            SEND: begin
               if (w_pop) begin
                  if (w_count_next == '0) begin
                     r_state <= IDLE;
                  end else if (p_send_intv_delay != 0) begin
                     r_state <= DELAY;
                     r_cnt   <= RELOAD;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_tail] <= w_send_msg;
   end

   assign val  = (r_state == SEND);
   assign msg  = val ? r_mem[r_head] : '0;
   assign idle = (r_count == '0) && (r_state == IDLE);

   // Blocks while in reset or full; a full queue being popped this cycle can
   // still take the push into the slot that frees.
   task automatic send(input t_msg m);
      while (rst || ((r_count == DEPTH) && !w_pop))
         @(negedge clk);
      w_send_msg = m;
      w_send_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      w_send_req = 1'b0;
   endtask

   function automatic logic done();
      return idle;
   endfunction

   function automatic logic [31:0] cycle_count();
      return w_cycle;
   endfunction

   function automatic logic timed_out();
      return w_timeout;
   endfunction

   function automatic string line_trace();
      string s;
      if (val && rdy) begin
         s = $sformatf("%h", msg);
      end else begin
         s = "";
         for (int i = 0; i < HEX_W - 1; i++)
            s = {s, " "};
         if (val)
            s = {s, "#"};
         else if (rdy)
            s = {s, " "};
         else
            s = {s, "."};
      end
      return s;
   endfunction

endmodule
